ldpc_dual_diag_backsub_param: RTL and testbench

- Parametrised, runtime-configurable successor to the fixed dual-diagonal back-substitution stage in the LDPC encoder.
- Accepts one frame of M syndrome blocks s_0..s_{M-1}, each Z bits wide, over a valid/ready stream.
- Solves the dual-diagonal parity structure (weight-3 first parity column, mid row selectable per frame) and emits M parity blocks p_0..p_{M-1} over a valid/ready stream with a last flag.
- Sits between the sparse-multiply-by-A stage and the GF(2) adder / multiply-by-E path.

---
 rtl/ldpc_dual_diag_backsub_param.sv | 205 ++++++++++++++++++++
 tb/tb_ldpc_dual_diag_backsub_param.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_dual_diag_backsub_param.sv
// ============================================================================
// Module      : ldpc_dual_diag_backsub_param
// Description : Runtime-configurable dual-diagonal back-substitution for the
//               LDPC encoder: collects M syndrome blocks, emits M parity blocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldpc_dual_diag_backsub_param #(
  parameter int Z        = 96,
  parameter int MAX_ROWS = 12,
  parameter int SHIFT    = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [Z-1:0]                  i_in_data,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic [$clog2(MAX_ROWS+1)-1:0] i_num_rows,
  input  logic [$clog2(MAX_ROWS)-1:0]   i_mid_row,
  output logic [Z-1:0]                  o_out_data,
  output logic                          o_out_valid,
  input  logic                          i_out_ready,
  output logic                          o_out_last,
  output logic                          o_cfg_error,
  output logic                          o_check_fail
);

  localparam int c_CNT_W = $clog2(MAX_ROWS + 1);
  localparam int c_IDX_W = $clog2(MAX_ROWS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_EMIT    = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [Z-1:0]         r_store [MAX_ROWS];
  logic [Z-1:0]         r_acc;
  logic [Z-1:0]         r_p0;
  logic [Z-1:0]         r_out_data;
  logic                 r_out_valid;
  logic                 r_out_last;
  logic                 r_in_ready;
  logic                 r_cfg_error;
  logic                 r_check_fail;
  logic                 r_cfg_bad;
  logic [c_CNT_W-1:0]   r_cnt_in;
  logic [c_CNT_W-1:0]   r_cnt_out;
  logic [c_CNT_W-1:0]   r_num_rows;
  logic [c_IDX_W-1:0]   r_mid_row;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_first;
  logic                 w_m_oor;
  logic                 w_cfg_bad;
  logic                 w_bad;
  logic                 w_in_last;
  logic                 w_out_is_last;
  logic                 w_check_bad;
  logic [c_IDX_W-1:0]   w_wr_idx;
  logic [c_IDX_W-1:0]   w_rd_idx;
  logic [Z-1:0]         w_acc_next;
  logic [Z-1:0]         w_s_cur;
  logic [Z-1:0]         w_p0_rot;
  logic [Z-1:0]         w_p_next;

  // out[i] = v[(i+SHIFT) mod Z]
  function automatic logic [Z-1:0] rot(input logic [Z-1:0] v);
    logic [Z-1:0] r;
    r = '0;
    for (int i = 0; i < Z; i++) begin
      r[i] = v[(i + SHIFT) % Z];
    end
    return r;
  endfunction

  assign w_in_fire  = i_in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;
  assign w_first    = (r_state == S_IDLE);

  // An out-of-range M swallows just one beat, so the first beat is also the last.
  assign w_m_oor   = (i_num_rows == '0) || (int'(i_num_rows) > MAX_ROWS);
  assign w_cfg_bad = (int'(i_num_rows) < 3) || (int'(i_num_rows) > MAX_ROWS) ||
                     (i_mid_row == '0) || (int'(i_mid_row) > int'(i_num_rows) - 2);
  assign w_bad     = w_first ? w_cfg_bad : r_cfg_bad;
  assign w_in_last = w_first ? (w_m_oor || (i_num_rows == c_CNT_W'(1)))
                             : (r_cnt_in == r_num_rows - c_CNT_W'(1));

  assign w_acc_next = w_first ? i_in_data : (r_acc ^ i_in_data);
  assign w_wr_idx   = w_first ? '0 : r_cnt_in[c_IDX_W-1:0];
  assign w_rd_idx   = r_cnt_out[c_IDX_W-1:0];
  assign w_s_cur    = r_store[w_rd_idx];
  assign w_p0_rot   = rot(r_p0);

  assign w_out_is_last = (r_cnt_out == r_num_rows - c_CNT_W'(1));
  assign w_p_next      = (r_cnt_out == '0) ? (w_s_cur ^ w_p0_rot)
                         : (r_out_data ^ w_s_cur ^
                            ((r_cnt_out == c_CNT_W'(r_mid_row)) ? r_p0 : '0));
  assign w_check_bad   = |(w_s_cur ^ w_p0_rot ^ r_out_data);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (w_in_fire) begin
          if (w_in_last) begin
            w_state_next = w_bad ? S_IDLE : S_EMIT;
          end else begin
            w_state_next = S_COLLECT;
          end
        end
      end
      S_EMIT: begin
        if (w_out_fire && w_out_is_last) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Syndrome store needs no reset: every entry is rewritten before it is read.
  always_ff @(posedge i_clock) begin
    if (w_in_fire) begin
      r_store[w_wr_idx] <= i_in_data;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_acc        <= '0;
      r_p0         <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cfg_error  <= 1'b0;
      r_check_fail <= 1'b0;
      r_cfg_bad    <= 1'b0;
      r_cnt_in     <= '0;
      r_cnt_out    <= '0;
      r_num_rows   <= '0;
      r_mid_row    <= '0;
    end else begin
      r_in_ready <= (w_state_next != S_EMIT);
      if (w_in_fire) begin
        r_acc    <= w_acc_next;
        r_cnt_in <= w_first ? c_CNT_W'(1) : r_cnt_in + c_CNT_W'(1);
        if (w_first) begin
          r_num_rows   <= i_num_rows;
          r_mid_row    <= i_mid_row;
          r_cfg_bad    <= w_cfg_bad;
          r_check_fail <= 1'b0;
          if (w_cfg_bad) begin
            r_cfg_error <= 1'b1;
          end
        end
        if (w_in_last && !w_bad) begin
          r_p0        <= w_acc_next;
          r_out_data  <= w_acc_next;
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_cnt_out   <= '0;
        end
      end
      if (w_out_fire) begin
        if (w_out_is_last) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_out_data  <= '0;
          if (w_check_bad) begin
            r_check_fail <= 1'b1;
          end
        end else begin
          r_out_data <= w_p_next;
          r_cnt_out  <= r_cnt_out + c_CNT_W'(1);
          r_out_last <= ((r_cnt_out + c_CNT_W'(1)) == (r_num_rows - c_CNT_W'(1)));
        end
      end
    end
  end

  assign o_in_ready   = r_in_ready;
  assign o_out_data   = r_out_data;
  assign o_out_valid  = r_out_valid;
  assign o_out_last   = r_out_last;
  assign o_cfg_error  = r_cfg_error;
  assign o_check_fail = r_check_fail;

endmodule

`default_nettype wire

// File: tb/tb_ldpc_dual_diag_backsub_param.sv
// ============================================================================
// Module      : tb_ldpc_dual_diag_backsub_param
// Description : Lockstep bench for a Z=8 and a Z=96 instance against a
//               closed-form parity model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldpc_dual_diag_backsub_param;

  localparam int MAXR = 12;
  localparam int SH   = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [3:0]  num_rows = '0;
  logic [3:0]  mid_row = '0;
  logic [7:0]  in_data8 = '0;
  logic [95:0] in_data96 = '0;

  logic        in_ready8, out_valid8, out_last8, cfg_error8, check_fail8;
  logic        in_ready96, out_valid96, out_last96, cfg_error96, check_fail96;
  logic [7:0]  out_data8;
  logic [95:0] out_data96;

  int n_vec = 0;
  int n_err = 0;

  logic [95:0] s8   [MAXR];
  logic [95:0] s96  [MAXR];
  logic [95:0] exp8 [MAXR];
  logic [95:0] exp96[MAXR];

  always #5 clk = ~clk;

  ldpc_dual_diag_backsub_param #(.Z(8), .MAX_ROWS(MAXR), .SHIFT(SH)) dut8 (
    .i_clock(clk), .i_reset(rst_n), .i_in_data(in_data8), .i_in_valid(in_valid),
    .o_in_ready(in_ready8), .i_num_rows(num_rows), .i_mid_row(mid_row),
    .o_out_data(out_data8), .o_out_valid(out_valid8), .i_out_ready(out_ready),
    .o_out_last(out_last8), .o_cfg_error(cfg_error8), .o_check_fail(check_fail8)
  );

  ldpc_dual_diag_backsub_param #(.Z(96), .MAX_ROWS(MAXR), .SHIFT(SH)) dut96 (
    .i_clock(clk), .i_reset(rst_n), .i_in_data(in_data96), .i_in_valid(in_valid),
    .o_in_ready(in_ready96), .i_num_rows(num_rows), .i_mid_row(mid_row),
    .o_out_data(out_data96), .o_out_valid(out_valid96), .i_out_ready(out_ready),
    .o_out_last(out_last96), .o_cfg_error(cfg_error96), .o_check_fail(check_fail96)
  );

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [95:0] rot_m(input logic [95:0] v, input int z);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < z; i++) r[i] = v[(i + SH) % z];
    return r;
  endfunction

  // p_i = s_0 ^ rot(p_0) ^ s_1 ^ .. ^ s_{i-1} ^ (i > x ? p_0 : 0) for i >= 1
  task automatic model(input int m, input int x);
    logic [95:0] p0a, p0b, runa, runb;
    p0a = '0;
    p0b = '0;
    for (int j = 0; j < m; j++) begin
      p0a ^= s8[j];
      p0b ^= s96[j];
    end
    exp8[0]  = p0a;
    exp96[0] = p0b;
    runa = s8[0] ^ rot_m(p0a, 8);
    runb = s96[0] ^ rot_m(p0b, 96);
    for (int i = 1; i < m; i++) begin
      exp8[i]  = runa ^ ((i > x) ? p0a : 96'd0);
      exp96[i] = runb ^ ((i > x) ? p0b : 96'd0);
      runa ^= s8[i];
      runb ^= s96[i];
    end
  endtask

  task automatic fill_random(input int m);
    for (int j = 0; j < m; j++) begin
      s8[j]  = {88'd0, 8'($urandom)};
      s96[j] = {$urandom, $urandom, $urandom};
    end
  endtask

  task automatic send_frame(input int m, input int x, input int nbeats);
    int cyc;
    bit ok;
    for (int j = 0; j < nbeats; j++) begin
      in_valid  = 1'b1;
      in_data8  = s8[j][7:0];
      in_data96 = s96[j];
      if (j == 0) begin
        num_rows = 4'(m);
        mid_row  = 4'(x);
      end else begin
        num_rows = 4'($urandom);
        mid_row  = 4'($urandom);
      end
      cyc = 0;
      ok  = 1'b0;
      while (!ok && cyc < 50) begin
        @(negedge clk);
        ok = in_ready8 & in_ready96;
        @(posedge clk);
        #1;
        cyc++;
      end
      chk("in_accept", ok, 1'b1);
    end
    in_valid = 1'b0;
  endtask

  task automatic recv(input int m, input int mode);
    int j, cyc;
    logic [5:0] pat;
    pat = 6'b101001;
    j   = 0;
    cyc = 0;
    while (j < m && cyc < 400) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc < 6) ? pat[cyc] : 1'b1;
        default: out_ready = 1'($urandom);
      endcase
      @(negedge clk);
      chk("in_ready_emit", {in_ready8, in_ready96}, 2'b00);
      chk("out_valid", {out_valid8, out_valid96}, 2'b11);
      chk("p8", {88'd0, out_data8}, exp8[j]);
      chk("p96", out_data96, exp96[j]);
      chk("last", {out_last8, out_last96}, (j == m - 1) ? 2'b11 : 2'b00);
      if (out_ready && out_valid8 && out_valid96) j++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("out_beats", j, m);
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_ready", {in_ready8, in_ready96}, 2'b11);
    chk("idle_valid", {out_valid8, out_valid96}, 2'b00);
    chk("check_fail", {check_fail8, check_fail96}, 2'b00);
    @(posedge clk);
    #1;
  endtask

  task automatic run_invalid(input int m, input int x, input int nbeats);
    send_frame(m, x, nbeats);
    @(negedge clk);
    chk("cfg_error", {cfg_error8, cfg_error96}, 2'b11);
    chk("inv_ready", {in_ready8, in_ready96}, 2'b11);
    repeat (3) begin
      @(negedge clk);
      chk("inv_no_out", {out_valid8, out_valid96}, 2'b00);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_basic();
    s8[0] = 96'h01;
    s8[1] = 96'h02;
    s8[2] = 96'h04;
    s8[3] = 96'h08;
    for (int j = 0; j < 4; j++) s96[j] = {$urandom, $urandom, $urandom};
    model(4, 1);
    exp8[0] = 96'h0F;
    exp8[1] = 96'h86;
    exp8[2] = 96'h8B;
    exp8[3] = 96'h8F;
  endtask

  initial begin
    int m, x;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {in_ready8, out_valid8, out_last8, cfg_error8, check_fail8, out_data8,
                       in_ready96, out_valid96, out_last96, cfg_error96, check_fail96}, '0);
    chk("reset_data96", out_data96, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_pre_edge", {in_ready8, in_ready96}, 2'b00);
    @(posedge clk);
    #1;
    chk("ready_post_edge", {in_ready8, in_ready96}, 2'b11);

    load_basic();
    send_frame(4, 1, 4);
    recv(4, 0);

    load_basic();
    send_frame(4, 1, 4);
    recv(4, 1);

    fill_random(2);
    run_invalid(2, 1, 2);
    fill_random(4);
    run_invalid(4, 0, 4);
    fill_random(1);
    run_invalid(13, 1, 1);
    load_basic();
    send_frame(4, 1, 4);
    recv(4, 0);

    load_basic();
    send_frame(4, 1, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {in_ready8, out_valid8, out_last8, cfg_error8, check_fail8, out_data8,
                        in_ready96, out_valid96, out_last96, cfg_error96, check_fail96}, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    load_basic();
    send_frame(4, 1, 4);
    recv(4, 0);

    for (int j = 0; j < 3; j++) begin
      s8[j]  = '0;
      s96[j] = '0;
    end
    model(3, 1);
    send_frame(3, 1, 3);
    recv(3, 2);

    for (int f = 0; f < 200; f++) begin
      if (f % 4 == 3) begin
        m = 3 + int'($urandom_range(0, 9));
        x = 1 + int'($urandom_range(0, m - 3));
      end else begin
        m = 12;
        x = 5;
      end
      fill_random(m);
      model(m, x);
      send_frame(m, x, m);
      recv(m, (f % 3 == 0) ? 0 : 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

endmodule

`default_nettype wire
